// File: rtl/ws2812_chain_driver.sv
// Self-timed WS2812 chain driver: preamble, per-pixel NRZ bit stream, latch low.
// Define LED_BRIGHTNESS_EN to add the global brightness port (each byte scaled on capture).
module ws2812_chain_driver #(
  parameter int LED_COUNT    = 8,
  parameter int COLOR_BITS   = 24,
  parameter int BIT_PERIOD   = 63,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int RESET_CYCLES = 2500,
  localparam int IDX_W       = $clog2(LED_COUNT + 1)
) (
  input  logic                  clk_50Mhz,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [COLOR_BITS-1:0] pix_data,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic                  dout,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun,
  output logic [IDX_W-1:0]      led_idx
`ifdef LED_BRIGHTNESS_EN
  ,
  input  logic [7:0]            brightness
`endif
);

  localparam int BW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int CW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;

  localparam logic [BW-1:0]    BIT_LAST   = BW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0]    T0H_C      = BW'(T0H);
  localparam logic [BW-1:0]    T1H_C      = BW'(T1H);
  localparam logic [RW-1:0]    RST_LAST   = RW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0]    COLOR_LAST = CW'(COLOR_BITS - 1);
  localparam logic [IDX_W-1:0] LED_LAST   = IDX_W'(LED_COUNT - 1);
  localparam logic [IDX_W-1:0] LED_MAX    = IDX_W'(LED_COUNT);

  typedef enum logic [1:0] {IDLE, PREAMBLE, SEND, LATCH} state_t;

  state_t                  state;
  logic [RW-1:0]           rst_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [BW-1:0]           bit_cnt_nxt;
  logic [BW-1:0]           high_time;
  logic [CW-1:0]           bit_idx;
  logic [COLOR_BITS-1:0]   shifter;
  logic [COLOR_BITS-1:0]   hold_data;
  logic [COLOR_BITS-1:0]   captured;
  logic                    hold_valid;
  logic [IDX_W-1:0]        req_cnt;
  logic                    handshake;

  assign pix_ready   = busy && !hold_valid && (req_cnt < LED_MAX);
  assign handshake   = pix_valid && pix_ready;
  assign high_time   = shifter[COLOR_BITS-1] ? T1H_C : T0H_C;
  assign bit_cnt_nxt = bit_cnt + BW'(1);

`ifdef LED_BRIGHTNESS_EN
  logic [16:0] scaled;
  always_comb begin
    captured = pix_data;
    scaled   = '0;
    for (int i = 0; i < COLOR_BITS / 8; i++) begin
      scaled = 17'(pix_data[i*8 +: 8]) * (17'(brightness) + 17'd1);
      captured[i*8 +: 8] = scaled[15:8];
    end
  end
`else
  always_comb begin
    captured = pix_data;
  end
`endif

  // Every bit period starts high because T0H > 0, so a load always drives dout to 1.
  always_ff @(posedge clk_50Mhz) begin
    if (!rst_n) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shifter    <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      req_cnt    <= '0;
      led_idx    <= '0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;

      if (handshake) begin
        hold_data  <= captured;
        hold_valid <= 1'b1;
        req_cnt    <= req_cnt + IDX_W'(1);
      end

      case (state)
        IDLE: begin
          if (start && !frame_done) begin
            state      <= PREAMBLE;
            busy       <= 1'b1;
            dout       <= 1'b0;
            rst_cnt    <= '0;
            req_cnt    <= '0;
            led_idx    <= '0;
            hold_valid <= 1'b0;
          end
        end

        PREAMBLE: begin
          if (rst_cnt != RST_LAST) begin
            rst_cnt <= rst_cnt + RW'(1);
          end else if (hold_valid) begin
            shifter    <= hold_data;
            hold_valid <= 1'b0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            dout       <= 1'b1;
            state      <= SEND;
          end
        end

        SEND: begin
          if (bit_cnt != BIT_LAST) begin
            bit_cnt <= bit_cnt_nxt;
            dout    <= (bit_cnt_nxt < high_time);
          end else if (bit_idx != COLOR_LAST) begin
            shifter <= shifter << 1;
            bit_idx <= bit_idx + CW'(1);
            bit_cnt <= '0;
            dout    <= 1'b1;
          end else begin
            led_idx <= led_idx + IDX_W'(1);
            if (led_idx == LED_LAST) begin
              state   <= LATCH;
              rst_cnt <= '0;
              dout    <= 1'b0;
            end else if (hold_valid) begin
              shifter    <= hold_data;
              hold_valid <= 1'b0;
              bit_cnt    <= '0;
              bit_idx    <= '0;
              dout       <= 1'b1;
            end else begin
              underrun <= 1'b1;
              state    <= LATCH;
              rst_cnt  <= '0;
              dout     <= 1'b0;
            end
          end
        end

        LATCH: begin
          if (rst_cnt != RST_LAST) begin
            rst_cnt <= rst_cnt + RW'(1);
          end else begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Bench for ws2812_chain_driver: frame table checked against a waveform model built from the bit rules.
module tb_ws2812_chain_driver;

  localparam int LC  = 3;
  localparam int CB  = 24;
  localparam int BP  = 63;
  localparam int T0  = 20;
  localparam int T1  = 40;
  localparam int R   = 2500;
  localparam int PIX = CB * BP;
  localparam int IW  = $clog2(LC + 1);

  logic          clk_50Mhz = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CB-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          dout;
  logic          busy;
  logic          frame_done;
  logic          underrun;
  logic [IW-1:0] led_idx;
`ifdef LED_BRIGHTNESS_EN
  logic [7:0]    brightness;
`endif

  int n_vectors     = 0;
  int n_miscompares = 0;
  int taken         = 0;
  logic [CB-1:0] supply_q[$];

  typedef struct {
    int                  nwords;
    logic [3:0][CB-1:0]  w;
    logic [7:0]          bright;
    bit                  glitch;
    int                  exp_taken;
    bit                  exp_underrun;
  } vec_t;

  vec_t vecs[5];

  ws2812_chain_driver #(
    .LED_COUNT(LC), .COLOR_BITS(CB), .BIT_PERIOD(BP),
    .T0H(T0), .T1H(T1), .RESET_CYCLES(R)
  ) dut (
    .clk_50Mhz (clk_50Mhz),
    .rst_n     (rst_n),
    .start     (start),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .dout      (dout),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun),
    .led_idx   (led_idx)
`ifdef LED_BRIGHTNESS_EN
    ,
    .brightness(brightness)
`endif
  );

  always #10 clk_50Mhz = ~clk_50Mhz;

  // Pixel source: presents the head of supply_q and pops it after each accepted handshake.
  initial begin
    logic hs;
    pix_valid = 1'b0;
    pix_data  = '0;
    forever begin
      @(negedge clk_50Mhz);
      hs = pix_valid && pix_ready;
      @(posedge clk_50Mhz);
      #1;
      if (hs === 1'b1 && supply_q.size() > 0) begin
        void'(supply_q.pop_front());
        taken++;
      end
      if (supply_q.size() > 0) begin
        pix_valid = 1'b1;
        pix_data  = supply_q[0];
      end else begin
        pix_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_50Mhz);
    #2;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vectors++;
    if (actual != expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [CB-1:0] expected_word(input vec_t v, input int i);
    logic [CB-1:0] w;
    w = v.w[i];
`ifdef LED_BRIGHTNESS_EN
    for (int f = 0; f < CB / 8; f++)
      w[f*8 +: 8] = 8'((int'(v.w[i][f*8 +: 8]) * (int'(v.bright) + 1)) >> 8);
`endif
    return w;
  endfunction

  task automatic applyStimulus(input vec_t v, input string tag);
    bit            e[$];
    logic [CB-1:0] px;
    bit            exp_d;
    int npix, len, exp_und_k, exp_idx, h;
    int dout_errs = 0, first_bad = 0, busy_errs = 0, idx_errs = 0;
    int done_k = 0, done_n = 0, und_k = 0, und_n = 0;

    supply_q.delete();
    taken = 0;
`ifdef LED_BRIGHTNESS_EN
    brightness = v.bright;
`endif
    for (int i = 0; i < v.nwords; i++) supply_q.push_back(v.w[i]);

    // Expected line: preamble zeros, each accepted pixel MSB first, latch zeros.
    npix = v.exp_taken;
    for (int i = 0; i < R; i++) e.push_back(1'b0);
    for (int p = 0; p < npix; p++) begin
      px = expected_word(v, p);
      for (int b = CB - 1; b >= 0; b--) begin
        h = px[b] ? T1 : T0;
        for (int c = 0; c < BP; c++) e.push_back(c < h);
      end
    end
    for (int i = 0; i < R; i++) e.push_back(1'b0);
    len       = e.size();
    exp_und_k = v.exp_underrun ? (R + npix * PIX + 1) : 0;

    start = 1'b1;
    for (int k = 1; k <= len + 4; k++) begin
      tick();
      start = 1'b0;
      exp_d = (k <= len) ? e[k-1] : 1'b0;
      if (dout !== exp_d) begin
        dout_errs++;
        if (first_bad == 0) first_bad = k;
      end
      if (busy !== (k <= len)) busy_errs++;
      exp_idx = (k <= R) ? 0 : (((k - R - 1) / PIX < npix) ? (k - R - 1) / PIX : npix);
      if (led_idx !== IW'(exp_idx)) idx_errs++;
      if (frame_done === 1'b1) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      if (underrun === 1'b1) begin
        und_n++;
        if (und_k == 0) und_k = k;
      end
      if (v.glitch && (k == R + 100 || k == len + 1)) start = 1'b1;
    end

    checkOutput($sformatf("%s dout_wave errors (first at k=%0d)", tag, first_bad), dout_errs, 0);
    checkOutput($sformatf("%s busy errors", tag), busy_errs, 0);
    checkOutput($sformatf("%s led_idx errors", tag), idx_errs, 0);
    checkOutput($sformatf("%s frame_done cycle", tag), done_k, len + 1);
    checkOutput($sformatf("%s frame_done pulses", tag), done_n, 1);
    checkOutput($sformatf("%s underrun cycle", tag), und_k, exp_und_k);
    checkOutput($sformatf("%s underrun pulses", tag), und_n, v.exp_underrun ? 1 : 0);
    checkOutput($sformatf("%s words taken", tag), taken, v.exp_taken);
    supply_q.delete();
  endtask

  // Reset pulled during the high phase of the first bit; everything must clear on the next edge.
  task automatic resetMidFrame();
    supply_q.delete();
    taken = 0;
    for (int i = 0; i < LC; i++) supply_q.push_back(CB'($urandom));
    start = 1'b1;
    for (int k = 1; k <= R + 5; k++) begin
      tick();
      start = 1'b0;
    end
    checkOutput("midreset dout high before reset", int'(dout), 1);
    rst_n = 1'b0;
    tick();
    checkOutput("midreset dout", int'(dout), 0);
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset pix_ready", int'(pix_ready), 0);
    checkOutput("midreset led_idx", int'(led_idx), 0);
    rst_n = 1'b1;
    supply_q.delete();
  endtask

  initial begin
    vecs[0].nwords = 3; vecs[0].w[0] = 24'hFF0000; vecs[0].w[1] = 24'h000001;
    vecs[0].w[2] = CB'($urandom); vecs[0].w[3] = '0; vecs[0].bright = 8'd255;
    vecs[0].glitch = 1'b0; vecs[0].exp_taken = 3; vecs[0].exp_underrun = 1'b0;

    vecs[1].nwords = 2; vecs[1].w[0] = CB'($urandom); vecs[1].w[1] = CB'($urandom);
    vecs[1].w[2] = '0; vecs[1].w[3] = '0; vecs[1].bright = 8'($urandom);
    vecs[1].glitch = 1'b0; vecs[1].exp_taken = 2; vecs[1].exp_underrun = 1'b1;

    vecs[2].nwords = 4; vecs[2].w[0] = CB'($urandom); vecs[2].w[1] = CB'($urandom);
    vecs[2].w[2] = CB'($urandom); vecs[2].w[3] = CB'($urandom); vecs[2].bright = 8'($urandom);
    vecs[2].glitch = 1'b1; vecs[2].exp_taken = 3; vecs[2].exp_underrun = 1'b0;

    vecs[3].nwords = 1; vecs[3].w[0] = 24'h80FF40; vecs[3].w[1] = '0;
    vecs[3].w[2] = '0; vecs[3].w[3] = '0; vecs[3].bright = 8'd127;
    vecs[3].glitch = 1'b0; vecs[3].exp_taken = 1; vecs[3].exp_underrun = 1'b1;

    vecs[4].nwords = 3; vecs[4].w[0] = CB'($urandom); vecs[4].w[1] = CB'($urandom);
    vecs[4].w[2] = CB'($urandom); vecs[4].w[3] = '0; vecs[4].bright = 8'($urandom);
    vecs[4].glitch = 1'b0; vecs[4].exp_taken = 3; vecs[4].exp_underrun = 1'b0;

    rst_n = 1'b0;
    start = 1'b0;
`ifdef LED_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    repeat (3) tick();
    checkOutput("reset dout", int'(dout), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset pix_ready", int'(pix_ready), 0);
    checkOutput("reset frame_done", int'(frame_done), 0);
    checkOutput("reset underrun", int'(underrun), 0);
    checkOutput("reset led_idx", int'(led_idx), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      if (i == 4) resetMidFrame();
      $display("[TB] frame vector %0d", i);
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
